ysyx_23060042_lsu: RTL



---
 rtl/ysyx_23060042_lsu.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060042_lsu.sv
// rtl/ysyx_23060042_lsu.sv - single-outstanding load/store unit on a req/gnt/rvalid bus
// Optional misalignment faulting: define YSYX_23060042_LSU_MISALIGN_EN.
module ysyx_23060042_lsu #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_op,
  input  logic        in_store,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit              LP_TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [1:0]       r_alo;
  logic             r_store;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic             r_out_valid;
  logic             r_out_err;
  logic [31:0]      r_out_rdata;

  logic             w_illegal;
  logic             w_misalign;
  logic             w_timeout;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ldata;

  assign w_illegal = (in_op == 3'b011) || (in_op[2:1] == 2'b11) || (in_store && in_op[2]);

`ifdef YSYX_23060042_LSU_MISALIGN_EN
  assign w_misalign = ((in_op[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_op[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Counter value on the last permitted REQ/WAIT cycle; the next edge aborts.
  assign w_timeout = LP_TO_EN && (r_cnt == LP_LAST);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = in_wdata;
    case (in_op[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {in_addr[1], 1'b0};
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = in_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_alo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_alo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_alo       <= 2'd0;
      r_store     <= 1'b0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_alo   <= in_addr[1:0];
            r_store <= in_store;
            r_cnt   <= '0;
            if (w_illegal || w_misalign) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_err   <= 1'b1;
              r_out_rdata <= 32'd0;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= in_store;
              r_mem_addr  <= {in_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_wstrb <= in_store ? w_wstrb : 4'd0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_state     <= S_DONE;
            r_mem_req   <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_rdata <= 32'd0;
          end else if (r_state == S_REQ) begin
            if (mem_gnt) begin
              r_state   <= S_WAIT;
              r_mem_req <= 1'b0;
            end
          end else if (mem_rvalid) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_out_rdata <= r_store ? 32'd0 : w_ldata;
          end
        end
        default: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign out_rdata = r_out_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
